// File: rtl/mode_sequencer.sv
// Clock mode sequencer: debounced three-button set-mode FSM with alarm arming and ringing.
// Optional feature: define AUTO_REPEAT_EN for b2 auto-repeat while held in a set state.
module mode_sequencer #(
  parameter int DEB_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_CYCLES   = 50,
  parameter int REPEAT_CYCLES  = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic alarm_match,
  output logic set_time,
  output logic set_alarm,
  output logic field,
  output logic inc,
  output logic alarm_en,
  output logic led
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 1 || BLINK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("mode_sequencer: cycle parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    A_HOUR = 3'd3,
    A_MIN  = 3'd4,
    RING   = 3'd5
  } state_t;

  logic [2:0]    btn_s;
  logic [2:0]    meta_r, sync_r, prev_r, level_r, arm_r, press_r;
  logic [DW-1:0] cnt_r [3];

  assign btn_s = {b3, b2, b1};

  // Synchronize, run-length debounce, and emit armed rising-edge press pulses.
  // arm_r stays low until a stable 0 is seen, so a button held through reset cannot fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_r  <= 3'b000;
      sync_r  <= 3'b000;
      prev_r  <= 3'b000;
      level_r <= 3'b000;
      arm_r   <= 3'b000;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      meta_r <= btn_s;
      sync_r <= meta_r;
      prev_r <= sync_r;
      for (int i = 0; i < 3; i++) begin
        if (sync_r[i] != prev_r[i]) begin
          cnt_r[i] <= DW'(1);
        end else if (cnt_r[i] != DW'(DEB_CYCLES)) begin
          cnt_r[i] <= cnt_r[i] + DW'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
        if (cnt_r[i] == DW'(DEB_CYCLES)) begin
          level_r[i] <= prev_r[i];
          arm_r[i]   <= arm_r[i] | ~prev_r[i];
          press_r[i] <= prev_r[i] & ~level_r[i] & arm_r[i];
        end else begin
          level_r[i] <= level_r[i];
          arm_r[i]   <= arm_r[i];
          press_r[i] <= 1'b0;
        end
      end
    end
  end

  logic p1_s, p2_s, p3_s, rise_s;
  logic am_prev_r;
  state_t state_r, state_n;
  logic [TW-1:0] to_r, to_n;
  logic [BW-1:0] blink_r, blink_n;
  logic alarm_en_n, inc_n, led_n;
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_r, rep_n;
`endif

  assign p1_s   = press_r[0];
  assign p2_s   = press_r[1];
  assign p3_s   = press_r[2];
  assign rise_s = alarm_match & ~am_prev_r;

  // Next-state and next-output logic; pulse priority is b3 over b1 over b2.
  always_comb begin
    state_n    = state_r;
    alarm_en_n = alarm_en;
    inc_n      = 1'b0;
    to_n       = '0;
    blink_n    = '0;
    led_n      = alarm_en;
`ifdef AUTO_REPEAT_EN
    rep_n      = '0;
`endif
    case (state_r)
      RUN: begin
        if (p3_s) begin
          alarm_en_n = ~alarm_en;
        end else if (p1_s) begin
          state_n = T_HOUR;
        end else if (rise_s && alarm_en) begin
          state_n = RING;
        end else begin
          state_n = RUN;
        end
      end
      T_HOUR, T_MIN, A_HOUR, A_MIN: begin
        if (p3_s) begin
          state_n = RUN;
        end else if (p1_s) begin
          state_n = (state_r == T_HOUR) ? T_MIN :
                    (state_r == T_MIN)  ? A_HOUR :
                    (state_r == A_HOUR) ? A_MIN : RUN;
        end else if (p2_s) begin
          inc_n = 1'b1;
`ifdef AUTO_REPEAT_EN
        end else if (level_r[1] && rep_r == RW'(REPEAT_CYCLES - 1)) begin
          inc_n = 1'b1;
`endif
        end else if (to_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = RUN;
        end else begin
          to_n = to_r + TW'(1);
`ifdef AUTO_REPEAT_EN
          rep_n = level_r[1] ? rep_r + RW'(1) : RW'(0);
`endif
        end
      end
      RING: begin
        if (p3_s) begin
          state_n = RUN;
        end else begin
          state_n = RING;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase

    if (state_n == RING) begin
      if (state_r != RING) begin
        led_n   = 1'b1;
        blink_n = '0;
      end else if (blink_r == BW'(BLINK_CYCLES - 1)) begin
        led_n   = ~led;
        blink_n = '0;
      end else begin
        led_n   = led;
        blink_n = blink_r + BW'(1);
      end
    end else begin
      led_n   = alarm_en_n;
      blink_n = '0;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= RUN;
      to_r      <= '0;
      blink_r   <= '0;
      am_prev_r <= 1'b0;
      set_time  <= 1'b0;
      set_alarm <= 1'b0;
      field     <= 1'b0;
      inc       <= 1'b0;
      alarm_en  <= 1'b0;
      led       <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_r     <= '0;
`endif
    end else begin
      state_r   <= state_n;
      to_r      <= to_n;
      blink_r   <= blink_n;
      am_prev_r <= alarm_match;
      set_time  <= (state_n == T_HOUR) || (state_n == T_MIN);
      set_alarm <= (state_n == A_HOUR) || (state_n == A_MIN);
      field     <= (state_n == T_MIN) || (state_n == A_MIN);
      inc       <= inc_n;
      alarm_en  <= alarm_en_n;
      led       <= led_n;
`ifdef AUTO_REPEAT_EN
      rep_r     <= rep_n;
`endif
    end
  end

endmodule
